xz_result_buffer: RTL and testbench
===================================

Name: xz_result_buffer

Overview:
- Downstream capture stage for the circuit4 datapath.
- Accepts the registered x/z result pair, which is produced free-running with no backpressure, into a small first-word-fall-through FIFO.
- Presents pairs to the consumer on a valid/ready handshake.
- Drops new results when full and records the loss in a sticky overflow flag, so a slow consumer never stalls the datapath.

Parameters:
- DATAWIDTH, 32, width of each of x and z.
- DEPTH, 8, number of x/z pair entries; must be a power of 2, minimum 2.
- ADDRW, 3, log2(DEPTH); pointer width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  x/z pair on in_x/in_z is valid this cycle.
- in_x  input  DATAWIDTH  x result from datapath.
- in_z  input  DATAWIDTH  z result from datapath.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head entry this cycle.
- out_x  output  DATAWIDTH  head entry x.
- out_z  output  DATAWIDTH  head entry z.
- count  output  ADDRW+1  current number of stored entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; a valid input was dropped.
- clr_ovf  input  1  synchronous clear of overflow (and of drop_cnt, if present).
- drop_cnt  output  16  dropped-sample counter (see Optional Feature).

Behaviour:
- Reset (rst=1, asynchronous): wr_ptr=0, rd_ptr=0, count=0, full=0, out_valid=0, out_x=0, out_z=0, overflow=0, drop_cnt=0. Storage array is not reset. Reset mid-operation discards all entries immediately.
- Definitions: pop = out_valid & out_ready; push = in_valid & (!full | pop).
- Push: at the clock edge, writes {in_x,in_z} to mem[wr_ptr], then wr_ptr += 1.
- Pop: rd_ptr += 1 at the edge.
- Pointers wrap modulo DEPTH with natural ADDRW-bit rollover.
- count: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- FWFT output:
  - out_valid = (count != 0).
  - out_x/out_z = mem[rd_ptr] when out_valid, else 0 (combinational from state).
  - Latency: a pair pushed at edge N is visible at out_* after edge N, with no extra cycle.
- Empty plus in_valid: push only; a pop is impossible that cycle.
- Full plus in_valid plus pop in the same cycle: both occur, count stays DEPTH, and nothing is dropped.
- Full plus in_valid without pop: the sample is dropped, storage and pointers are unchanged, and overflow is set to 1 at the edge.
- overflow is cleared at the edge when clr_ovf=1. If a drop and clr_ovf occur in the same cycle, set wins (overflow=1).
- out_ready while out_valid=0 is ignored.
- in_x/in_z are ignored when in_valid=0.
- There is no width conversion: x/z are stored exactly as DATAWIDTH bits.

Optional Feature:
- Macro: XZ_BUF_DROP_CNT_EN.
- Defined:
  - drop_cnt increments by 1 on every dropped sample and saturates at 16'hFFFF (no wrap).
  - drop_cnt is cleared by clr_ovf.
  - If a drop and clr_ovf occur in the same cycle, drop_cnt = 1.
  - Reset value is 0.
- Not defined: drop_cnt is tied to 16'h0000 and no counter logic is synthesized. The port still exists.

Test Plan:
- Reset with in_valid=1: assert rst mid-stream after 3 pushes -> count=0, out_valid=0, out_x=out_z=0 immediately (before the next edge); the first push after release appears at out_* one edge later.
- Ordering and wrap: push 12 pairs (x=i, z=100+i, i=0..11) with out_ready=1 from cycle 4 -> pops occur in order 0..11 with no loss, pointers wrap past 7, overflow=0.
- Fill to full: 8 pushes with out_ready=0 -> full=1, count=8. A 9th push (x=0xDEAD) -> dropped, overflow=1, count=8, drop_cnt=1 (macro on) / 0 (macro off). Then drain -> 8 original pairs and no 0xDEAD.
- Full with simultaneous push and pop: count=8, in_valid=1 (x=0x55), out_ready=1 -> count stays 8, overflow stays 0, 0x55 emerges last.
- Clear priority: overflow=1, then a cycle with clr_ovf=1 and a drop together -> overflow=1, drop_cnt=1. Next cycle, clr_ovf=1 with no drop -> overflow=0, drop_cnt=0.
- Saturation (macro on): force 70000 drops with out_ready=0 -> drop_cnt=16'hFFFF and holds there.

Source files
------------

// File: rtl/xz_result_buffer.sv
// xz_result_buffer
//   Capture stage for the circuit4 x/z result pair. The datapath produces
//   pairs free-running with no backpressure. Pairs enter a small
//   first-word-fall-through FIFO and are offered to the consumer on a
//   valid/ready handshake. When the FIFO is full and no pop happens, a new
//   pair is dropped, and the loss is recorded in a sticky overflow flag.
//
// Optional feature (macro XZ_BUF_DROP_CNT_EN):
//   When defined, drop_cnt counts dropped pairs and saturates at 16'hFFFF.
//   clr_ovf clears the counter. When not defined, drop_cnt is tied to zero.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   in_x/in_z carry a valid pair this cycle
//   in_x/in_z  x/z result from datapath (DATAWIDTH each)
//   out_valid  head entry available
//   out_ready  consumer takes the head entry this cycle
//   out_x/z    head entry, zero while empty
//   count      stored entries, 0..DEPTH
//   full       count == DEPTH
//   overflow   sticky, a valid input was dropped
//   clr_ovf    synchronous clear of overflow and drop_cnt
//   drop_cnt   dropped-sample counter (zero unless XZ_BUF_DROP_CNT_EN)
module xz_result_buffer #(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 8,
    parameter int ADDRW     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATAWIDTH-1:0] in_x,
    input  logic [DATAWIDTH-1:0] in_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_x,
    output logic [DATAWIDTH-1:0] out_z,
    output logic [ADDRW:0]       count,
    output logic                 full,
    output logic                 overflow,
    input  logic                 clr_ovf,
    output logic [15:0]          drop_cnt
);

    localparam logic [ADDRW:0] FULL_COUNT = (ADDRW+1)'(DEPTH);

    logic [2*DATAWIDTH-1:0] mem [DEPTH];
    logic [ADDRW-1:0]       wr_ptr;
    logic [ADDRW-1:0]       rd_ptr;
    logic [ADDRW:0]         count_q;
    logic                   overflow_q;
    logic                   pop;
    logic                   push;
    logic                   drop;

    assign out_valid = (count_q != '0);
    assign full      = (count_q == FULL_COUNT);
    assign count     = count_q;
    assign overflow  = overflow_q;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign pop  = out_valid & out_ready;
    assign push = in_valid & (~full | pop);
    assign drop = in_valid & full & ~pop;

    // Storage is not reset. Only entries below count are ever presented.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_x, in_z};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDRW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDRW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (ADDRW+1)'(1);
                2'b01:   count_q <= count_q - (ADDRW+1)'(1);
                default: count_q <= count_q;
            endcase
            // A drop in the same cycle as a clear takes priority.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Fall-through head. The output is forced to zero while the FIFO is empty.
    always_comb begin
        out_x = '0;
        out_z = '0;
        if (out_valid) begin
            {out_x, out_z} = mem[rd_ptr];
        end
    end

`ifdef XZ_BUF_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop) begin
            if (clr_ovf) begin
                drop_cnt_q <= 16'd1;
            end else if (drop_cnt_q != '1) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end else if (clr_ovf) begin
            drop_cnt_q <= '0;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_xz_result_buffer.sv
// tb_xz_result_buffer
//   Testbench for xz_result_buffer. It compares the DUT against a queue
//   reference model and a table of fixed vectors. Accepted pairs go into the
//   queue when they are driven. The queue is checked against out_x/out_z on
//   every handshake.
module tb_xz_result_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int ADDRW = 3;

`ifdef XZ_BUF_DROP_CNT_EN
    localparam logic [15:0] EXP_DROP1 = 16'd1;
`else
    localparam logic [15:0] EXP_DROP1 = 16'd0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_x;
    logic [DW-1:0] in_z;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_x;
    logic [DW-1:0] out_z;
    logic [ADDRW:0] count;
    logic          full;
    logic          overflow;
    logic          clr_ovf;
    logic [15:0]   drop_cnt;

    xz_result_buffer #(.DATAWIDTH(DW), .DEPTH(DEPTH), .ADDRW(ADDRW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_x(in_x), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_z(out_z),
        .count(count), .full(full), .overflow(overflow), .clr_ovf(clr_ovf),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [2*DW-1:0] mq[$];
    logic            m_ovf;
    logic [15:0]     m_dcnt;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        bit          iv;
        logic [31:0] x;
        logic [31:0] z;
        bit          rdy;
        bit          clr;
        int unsigned exp_count;
        bit          exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        logic [63:0] head;
        head = (mq.size() != 0) ? mq[0] : 64'd0;
        check("count", 64'(count), 64'(mq.size()));
        check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        check("full", 64'(full), 64'(mq.size() == DEPTH));
        check("overflow", 64'(overflow), 64'(m_ovf));
`ifdef XZ_BUF_DROP_CNT_EN
        check("drop_cnt", 64'(drop_cnt), 64'(m_dcnt));
`else
        check("drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        check("head_data", {out_x, out_z}, head);
    endtask

    // Call this 1 time unit after a rising edge. It drives inputs, scores the
    // handshake, advances one clock, and checks the new state.
    task automatic step(input bit iv, input logic [31:0] x, input logic [31:0] z,
                        input bit rdy, input bit clr);
        logic [63:0] head;
        bit p_pop, p_drop, p_push;
        in_valid  = iv;
        in_x      = x;
        in_z      = z;
        out_ready = rdy;
        clr_ovf   = clr;
        #1;
        p_pop  = rdy && (mq.size() != 0);
        p_drop = iv && (mq.size() == DEPTH) && !p_pop;
        p_push = iv && !p_drop;
        if (p_pop) begin
            head = mq.pop_front();
            check("pop_data", {out_x, out_z}, head);
        end
        if (p_push) mq.push_back({x, z});
        if (p_drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (p_drop) begin
            if (clr) m_dcnt = 16'd1;
            else if (m_dcnt != 16'hFFFF) m_dcnt = m_dcnt + 16'd1;
        end else if (clr) begin
            m_dcnt = 16'd0;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_x = '0; in_z = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        mq.delete();
        m_ovf  = 1'b0;
        m_dcnt = 16'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_state();
    endtask

    task automatic fill(input logic [31:0] base);
        for (int unsigned i = 0; i < DEPTH; i++) step(1'b1, base + i, base + 32'h1000 + i, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int unsigned guard = 0;
        while (mq.size() != 0 && guard < 4 * DEPTH) begin
            step(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
            guard++;
        end
        check("drained", 64'(count), 64'd0);
    endtask

    initial begin
        vecs[0] = '{1, 32'd1, 32'd11, 0, 0, 1, 0};
        vecs[1] = '{1, 32'd2, 32'd12, 0, 0, 2, 0};
        vecs[2] = '{1, 32'd3, 32'd13, 1, 0, 2, 0};
        vecs[3] = '{0, 32'hBAD, 32'hBAD, 1, 0, 1, 0};
        vecs[4] = '{0, 32'hBAD, 32'hBAD, 0, 1, 1, 0};
        vecs[5] = '{1, 32'd5, 32'd15, 1, 0, 1, 0};
        vecs[6] = '{0, 32'hBAD, 32'hBAD, 1, 0, 0, 0};
        vecs[7] = '{0, 32'hBAD, 32'hBAD, 1, 0, 0, 0};
        vecs[8] = '{1, 32'd7, 32'd17, 1, 0, 1, 0};
        vecs[9] = '{0, 32'hBAD, 32'hBAD, 1, 0, 0, 0};

        apply_reset();

        // Table-driven basic handshake vectors
        for (int unsigned i = 0; i < 10; i++) begin
            step(vecs[i].iv, vecs[i].x, vecs[i].z, vecs[i].rdy, vecs[i].clr);
            check("vec_count", 64'(count), 64'(vecs[i].exp_count));
            check("vec_ovf", 64'(overflow), 64'(vecs[i].exp_ovf));
        end

        // Asynchronous reset mid-stream with in_valid held high
        apply_reset();
        for (int unsigned i = 0; i < 3; i++) step(1'b1, 32'h40 + i, 32'h50 + i, 1'b0, 1'b0);
        in_valid = 1'b1; in_x = 32'h99; in_z = 32'h99;
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_count", 64'(count), 64'd0);
        check("rst_async_valid", 64'(out_valid), 64'd0);
        check("rst_async_data", {out_x, out_z}, 64'd0);
        mq.delete(); m_ovf = 1'b0; m_dcnt = 16'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_state();
        step(1'b1, 32'h77, 32'h78, 1'b0, 1'b0);
        check("post_rst_x", 64'(out_x), 64'h77);
        drain();

        // Ordering and pointer wrap
        apply_reset();
        for (int unsigned i = 0; i < 12; i++) step(1'b1, i, 100 + i, i >= 4, 1'b0);
        drain();
        check("wrap_ovf", 64'(overflow), 64'd0);

        // Fill to full, drop one, then drain the originals
        apply_reset();
        fill(32'h10);
        check("full_flag", 64'(full), 64'd1);
        check("full_count", 64'(count), 64'd8);
        step(1'b1, 32'hDEAD, 32'hDEAD, 1'b0, 1'b0);
        check("drop_ovf", 64'(overflow), 64'd1);
        check("drop_count", 64'(count), 64'd8);
        check("drop_cnt1", 64'(drop_cnt), 64'(EXP_DROP1));
        drain();

        // Full with simultaneous push and pop
        apply_reset();
        fill(32'h200);
        step(1'b1, 32'h55, 32'h55, 1'b1, 1'b0);
        check("pp_count", 64'(count), 64'd8);
        check("pp_ovf", 64'(overflow), 64'd0);
        for (int unsigned i = 0; i < DEPTH - 1; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("pp_last", 64'(out_x), 64'h55);
        drain();

        // Clear priority: a drop beats clr_ovf
        apply_reset();
        fill(32'h300);
        step(1'b1, 32'hA, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 32'hB, 1'b0, 1'b1);
        check("clr_drop_ovf", 64'(overflow), 64'd1);
        check("clr_drop_cnt", 64'(drop_cnt), 64'(EXP_DROP1));
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("clr_ovf", 64'(overflow), 64'd0);
        check("clr_cnt", 64'(drop_cnt), 64'd0);
        drain();

`ifdef XZ_BUF_DROP_CNT_EN
        // Saturation: 70000 drops while full
        apply_reset();
        fill(32'h400);
        in_valid = 1'b1; out_ready = 1'b0; clr_ovf = 1'b0;
        for (int unsigned i = 0; i < 70000; i++) begin
            @(posedge clk);
        end
        #1;
        m_ovf  = 1'b1;
        m_dcnt = 16'hFFFF;
        check("sat_cnt", 64'(drop_cnt), 64'hFFFF);
        step(1'b1, 32'h1, 32'h1, 1'b0, 1'b0);
        check("sat_hold", 64'(drop_cnt), 64'hFFFF);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
